// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam int DEFAULT_NUM_LINES = 8;

    function automatic int calc_index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int num_lines);
        return 15 - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid, dirty, tag and data per one-word line.
// One combinational read port and one synchronous write port sharing an index.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEFAULT_NUM_LINES,
    parameter int INDEX_W   = calc_index_w(NUM_LINES),
    parameter int TAG_W     = calc_tag_w(NUM_LINES)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [INDEX_W-1:0] index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [15:0]        rd_data,
    input  logic               data_we,
    input  logic [15:0]        wr_data,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_valid,
    input  logic               dirty_we,
    input  logic               wr_dirty
);

    logic              valid_q [NUM_LINES];
    logic              dirty_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [15:0]       data_q  [NUM_LINES];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];

    // Status bits: clear wins over any write so a reset always empties the cache.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            if (tag_we) begin
                valid_q[index] <= wr_valid;
            end
            if (dirty_we) begin
                dirty_q[index] <= wr_dirty;
            end
        end
    end

    // Payload storage is never reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[index] <= wr_data;
        end
        if (tag_we) begin
            tag_q[index] <= wr_tag;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache controller: hit path answers in the request cycle, misses
// write back a dirty victim (if any), fill from memory, then finish.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEFAULT_NUM_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int INDEX_W = calc_index_w(NUM_LINES);
    localparam int TAG_W   = calc_tag_w(NUM_LINES);

    state_t state;
    state_t next_state;

    logic [14:0]        req_word;
    logic [15:0]        req_data;
    logic               req_wr;
    logic               latch_req;

    logic [INDEX_W-1:0] in_index;
    logic [TAG_W-1:0]   in_tag;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] arr_index;

    logic               is_req;
    logic               illegal;
    logic               hit;

    logic               rd_valid;
    logic               rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [15:0]        rd_data;
    logic               data_we;
    logic [15:0]        wr_data;
    logic               tag_we;
    logic               dirty_we;
    logic               wr_dirty;

    assign in_index  = Addr[INDEX_W:1];
    assign in_tag    = Addr[15:INDEX_W+1];
    assign req_index = req_word[INDEX_W-1:0];
    assign req_tag   = req_word[14:INDEX_W];

    // In IDLE the array looks at the incoming address; afterwards it stays on the latched line.
    assign arr_index = (state == ST_IDLE) ? in_index : req_index;

    assign is_req  = Rd | Wr;
    assign illegal = (Rd & Wr) | (is_req & Addr[0]);
    assign hit     = rd_valid & (rd_tag == in_tag);

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .clear    (rst),
        .index    (arr_index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .data_we  (data_we),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (req_tag),
        .wr_valid (1'b1),
        .dirty_we (dirty_we),
        .wr_dirty (wr_dirty)
    );

    // State register; reset drops any in-flight memory transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request registers capture the missing access so the processor side may change freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_word <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
        end else if (latch_req) begin
            req_word <= Addr[15:1];
            req_data <= DataIn;
            req_wr   <= Wr;
        end
    end

    // Next-state, handshake outputs, memory requests and array write controls.
    always_comb begin
        next_state = state;
        DataOut    = '0;
        Done       = 1'b0;
        Stall      = 1'b0;
        CacheHit   = 1'b0;
        err        = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        latch_req  = 1'b0;
        data_we    = 1'b0;
        wr_data    = DataIn;
        tag_we     = 1'b0;
        dirty_we   = 1'b0;
        wr_dirty   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (is_req) begin
                    if (illegal) begin
                        err  = 1'b1;
                        Done = 1'b1;
                    end else if (hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = rd_data;
                        if (Wr) begin
                            data_we  = 1'b1;
                            wr_data  = DataIn;
                            dirty_we = 1'b1;
                            wr_dirty = 1'b1;
                        end
                    end else begin
                        Stall      = 1'b1;
                        latch_req  = 1'b1;
                        next_state = (rd_valid && rd_dirty) ? ST_WB : ST_FILL;
                    end
                end
            end
            ST_WB: begin
                Stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {rd_tag, req_index, 1'b0};
                mem_wdata = rd_data;
                if (mem_ready) begin
                    dirty_we   = 1'b1;
                    wr_dirty   = 1'b0;
                    next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                Stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {req_word, 1'b0};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    wr_data    = mem_rdata;
                    tag_we     = 1'b1;
                    dirty_we   = 1'b1;
                    wr_dirty   = 1'b0;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                Done       = 1'b1;
                next_state = ST_IDLE;
                if (req_wr) begin
                    data_we  = 1'b1;
                    wr_data  = req_data;
                    dirty_we = 1'b1;
                    wr_dirty = 1'b1;
                end else begin
                    DataOut = rd_data;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (rst) begin
            data_we  = 1'b0;
            tag_we   = 1'b0;
            dirty_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// traffic, checked against a behavioural model of cache lines and main memory.
module tb_dcache_ctrl;

    localparam int NL = 8;
    localparam int IW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    dcache_ctrl #(.NUM_LINES(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each line remembers the full word address it holds.
    logic        m_valid [NL];
    logic        m_dirty [NL];
    logic [14:0] m_word  [NL];
    logic [15:0] m_data  [NL];
    logic [15:0] mem_store [int];

    function automatic logic [15:0] memRead(input logic [14:0] w);
        if (mem_store.exists(int'(w))) return mem_store[int'(w)];
        return {1'b1, w ^ 15'h2B3C};
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".Done"},     16'(Done),     16'd0);
        checkOutput({tag, ".Stall"},    16'(Stall),    16'd0);
        checkOutput({tag, ".CacheHit"}, 16'(CacheHit), 16'd0);
        checkOutput({tag, ".err"},      16'(err),      16'd0);
        checkOutput({tag, ".mem_rd"},   16'(mem_rd),   16'd0);
        checkOutput({tag, ".mem_wr"},   16'(mem_wr),   16'd0);
        checkOutput({tag, ".DataOut"},  DataOut,       16'd0);
    endtask

    // One processor request, run to completion cycle by cycle against the model.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int wbLat, input int fillLat);
        logic [IW-1:0] idx;
        logic [14:0]   word;
        logic [15:0]   fillData;
        idx  = addr[IW:1];
        word = addr[15:1];

        Rd = rd; Wr = wr; Addr = addr; DataIn = wdata;
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        @(negedge clk);

        if (!rd && !wr) begin
            checkQuiet("idle");
            nextCycle();
            return;
        end

        if ((rd && wr) || addr[0]) begin
            checkOutput("illegal.err",    16'(err),    16'd1);
            checkOutput("illegal.Done",   16'(Done),   16'd1);
            checkOutput("illegal.Stall",  16'(Stall),  16'd0);
            checkOutput("illegal.mem_rd", 16'(mem_rd), 16'd0);
            checkOutput("illegal.mem_wr", 16'(mem_wr), 16'd0);
            nextCycle();
            Rd = 1'b0; Wr = 1'b0;
            return;
        end

        if (m_valid[idx] && m_word[idx] == word) begin
            checkOutput("hit.Done",     16'(Done),     16'd1);
            checkOutput("hit.CacheHit", 16'(CacheHit), 16'd1);
            checkOutput("hit.Stall",    16'(Stall),    16'd0);
            checkOutput("hit.err",      16'(err),      16'd0);
            checkOutput("hit.mem_rd",   16'(mem_rd),   16'd0);
            checkOutput("hit.mem_wr",   16'(mem_wr),   16'd0);
            checkOutput("hit.DataOut",  DataOut,       m_data[idx]);
            nextCycle();
            if (wr) begin
                m_data[idx]  = wdata;
                m_dirty[idx] = 1'b1;
            end
            Rd = 1'b0; Wr = 1'b0;
            return;
        end

        checkOutput("miss.Stall", 16'(Stall), 16'd1);
        checkOutput("miss.Done",  16'(Done),  16'd0);
        checkOutput("miss.err",   16'(err),   16'd0);
        nextCycle();

        if (m_valid[idx] && m_dirty[idx]) begin
            for (int c = 1; c <= wbLat; c++) begin
                mem_ready = (c == wbLat);
                Addr = 16'($urandom); DataIn = 16'($urandom);
                @(negedge clk);
                checkOutput("wb.mem_wr",    16'(mem_wr), 16'd1);
                checkOutput("wb.mem_rd",    16'(mem_rd), 16'd0);
                checkOutput("wb.mem_addr",  mem_addr,    {m_word[idx], 1'b0});
                checkOutput("wb.mem_wdata", mem_wdata,   m_data[idx]);
                checkOutput("wb.Stall",     16'(Stall),  16'd1);
                checkOutput("wb.Done",      16'(Done),   16'd0);
                nextCycle();
            end
            mem_store[int'(m_word[idx])] = m_data[idx];
            m_dirty[idx] = 1'b0;
        end

        fillData = memRead(word);
        for (int c = 1; c <= fillLat; c++) begin
            mem_ready = (c == fillLat);
            mem_rdata = (c == fillLat) ? fillData : 16'($urandom);
            Addr = 16'($urandom); DataIn = 16'($urandom);
            @(negedge clk);
            checkOutput("fill.mem_rd",   16'(mem_rd), 16'd1);
            checkOutput("fill.mem_wr",   16'(mem_wr), 16'd0);
            checkOutput("fill.mem_addr", mem_addr,    {word, 1'b0});
            checkOutput("fill.Stall",    16'(Stall),  16'd1);
            checkOutput("fill.Done",     16'(Done),   16'd0);
            nextCycle();
        end
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_word[idx]  = word;
        m_data[idx]  = fillData;

        Rd = 1'($urandom); Wr = 1'($urandom); Addr = 16'($urandom);
        DataIn = 16'($urandom); mem_ready = 1'($urandom);
        @(negedge clk);
        checkOutput("done.Done",     16'(Done),     16'd1);
        checkOutput("done.CacheHit", 16'(CacheHit), 16'd0);
        checkOutput("done.Stall",    16'(Stall),    16'd0);
        checkOutput("done.err",      16'(err),      16'd0);
        checkOutput("done.mem_rd",   16'(mem_rd),   16'd0);
        checkOutput("done.mem_wr",   16'(mem_wr),   16'd0);
        if (!wr) checkOutput("done.DataOut", DataOut, fillData);
        nextCycle();
        if (wr) begin
            m_data[idx]  = wdata;
            m_dirty[idx] = 1'b1;
        end
        Rd = 1'b0; Wr = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkQuiet(tag);
        checkOutput({tag, ".mem_addr"},  mem_addr,  16'd0);
        checkOutput({tag, ".mem_wdata"}, mem_wdata, 16'd0);
    endtask

    initial begin
        logic [15:0] tags [4];
        int          op;
        logic [15:0] a;
        tags[0] = 16'h0000; tags[1] = 16'h0001; tags[2] = 16'h00AB; tags[3] = 16'h0FFF;

        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        clearModel();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");
        nextCycle();

        // Clean load miss, then repeat hit, store hit, load hit.
        mem_store[int'(15'h0008)] = 16'hBEEF;
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 3);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1);
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234, 1, 1);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1);

        // Illegal requests leave the cache alone.
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h5555, 1, 1);
        applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000, 1, 1);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1);

        // Dirty eviction of 0x0010 by 0x0110.
        applyStimulus(1'b1, 1'b0, 16'h0110, 16'h0000, 2, 2);

        // Reset in the second fill cycle aborts the transfer.
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0030; mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("rstfill.Stall", 16'(Stall), 16'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("rstfill.mem_rd", 16'(mem_rd), 16'd1);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0; Rd = 1'b0;
        @(negedge clk);
        checkResetOutputs("rstfill.after");
        clearModel();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000, 1, 2);

        // Single-cycle memory: store miss, hit, then eviction with write-back.
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h00FF, 1, 1);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1, 1);
        applyStimulus(1'b1, 1'b0, 16'h0120, 16'h0000, 1, 1);

        // Random traffic over a small address pool to mix hits, misses and evictions.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 12);
            a  = {tags[$urandom_range(0, 3)][11:0], 3'($urandom), 1'b0};
            if (op <= 5) begin
                applyStimulus(1'b1, 1'b0, a, 16'h0000, $urandom_range(1, 4), $urandom_range(1, 4));
            end else if (op <= 10) begin
                applyStimulus(1'b0, 1'b1, a, 16'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
            end else if (op == 11) begin
                if ($urandom_range(0, 1) == 1)
                    applyStimulus(1'b1, 1'b1, a, 16'($urandom), 1, 1);
                else
                    applyStimulus(1'($urandom), 1'b1, a | 16'h0001, 16'($urandom), 1, 1);
            end else begin
                applyStimulus(1'b0, 1'b0, a, 16'h0000, 1, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Responder end of the processor's data-memory stall handshake: accepts one load/store per request from the memory stage and drops `Stall` when it finishes. Holds a direct-mapped, write-back, write-allocate cache of single-word lines. On a miss, it acts as initiator toward a variable-latency backing memory. It sits between the memory stage and main memory, and its `Stall` output is the processor's `Dmem_Stall`.

## Interface
- NUM_LINES, 8, number of one-word lines; power of two, ≥2; INDEX_W = log2(NUM_LINES), TAG_W = 15 − INDEX_W
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Addr  in  16  byte address; word = Addr[15:1], index = Addr[INDEX_W:1], tag = Addr[15:INDEX_W+1]
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data, valid when Done=1
- Done  out  1  request complete this cycle
- Stall  out  1  request in progress; processor freezes its pipeline
- CacheHit  out  1  with Done: request hit without memory traffic
- err  out  1  illegal request (Rd&Wr, or Addr[0]=1 with Rd|Wr)
- mem_addr  out  16  backing-memory word address (byte address, bit0=0)
- mem_wdata  out  16  write-back data
- mem_rd  out  1  fill request, held until mem_ready
- mem_wr  out  1  write-back request, held until mem_ready
- mem_rdata  in  16  fill data, valid when mem_ready & mem_rd
- mem_ready  in  1  backing memory completes the held transfer this cycle

## Operation
- Storage per line: valid, dirty, tag[TAG_W], data[16]. Reset clears all valid and dirty bits; data and tags are unchanged.
- States: IDLE, WB, FILL, DONE.
- **IDLE**
  - Rd^Wr with aligned Addr: lookup is combinational.
  - Hit: Done=1, CacheHit=1, Stall=0, DataOut=line data. A store writes DataIn and sets dirty at the edge. Stay in IDLE.
  - Miss: Stall=1. Latch Addr, DataIn and Wr into request registers. Go to WB if the victim is valid&dirty, else go to FILL.
  - Illegal request: err=1, Done=1, Stall=0, no state change, cache untouched.
  - No request: all handshake outputs are 0.
- **WB**
  - mem_wr=1, mem_addr={victim tag, index, 1'b0}, mem_wdata=victim data, Stall=1.
  - On mem_ready: clear dirty, go to FILL.
- **FILL**
  - mem_rd=1, mem_addr=latched word address, Stall=1.
  - On mem_ready: write the line with tag=latched tag, valid=1, dirty=0, data=mem_rdata, then go to DONE.
- **DONE**
  - Done=1, CacheHit=0, Stall=0.
  - Load: DataOut=line data.
  - Store: write the latched DataIn into the line and set dirty at the edge.
  - Always return to IDLE. Rd/Wr seen in DONE are ignored; the processor re-presents them in the next cycle.
- mem_rd and mem_wr are never both 1. Both are 0 outside WB/FILL.
- err is asserted only in IDLE and is never sticky.

## Timing
- Reset values: state=IDLE; DataOut=0, Done=0, Stall=0, CacheHit=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset during WB/FILL aborts the transfer: mem_rd and mem_wr are 0 in the cycle after rst.
- Hit: Done in the request cycle (zero added latency).
- Clean miss, request at cycle 0:
  - FILL starts at cycle 1.
  - mem_ready arrives at cycle k ≥ 1.
  - Done comes at cycle k+1, and Stall is high for cycles 0..k.
- Dirty miss: add the WB cycles, i.e. the number of cycles up to and including WB's mem_ready.
- mem_ready is sampled only in WB/FILL and ignored elsewhere. mem_ready in the first WB/FILL cycle is legal (single-cycle memory).
- Stall and Done are mutually exclusive in every cycle.

## Structure
- Shared package dcache_pkg holds:
  - the state encoding (IDLE, WB, FILL, DONE);
  - the default NUM_LINES;
  - the INDEX_W/TAG_W derivation functions.
- One sub-module, dcache_array, holds the valid, dirty, tag and data arrays, with:
  - one combinational read port by index;
  - one synchronous write port with separate write enables for data/tag/valid and dirty;
  - a synchronous clear of valid and dirty.
- The FSM, request registers and output muxing stay in dcache_ctrl.

## Test plan
- Load Addr=0x0010 after reset, mem_ready 3 cycles after mem_rd, mem_rdata=0xBEEF → Stall high 4 cycles, then Done=1, CacheHit=0, DataOut=0xBEEF. A repeat load gives Done=1, CacheHit=1 in the same cycle.
- Store 0x1234 to 0x0010, then load 0x0010 → both hit; DataOut=0x1234, no mem_rd/mem_wr activity.
- Dirty line at 0x0010 (0x1234), then load 0x0110 (same index, new tag) → mem_wr with mem_addr=0x0010 and mem_wdata=0x1234 first, then mem_rd with mem_addr=0x0110, then Done.
- Rd=Wr=1, and separately Rd=1 with Addr=0x0011 → err=1, Done=1, Stall=0, no memory request; a following load of the previously cached 0x0010 still hits.
- Assert rst in the second FILL cycle → mem_rd=0 the next cycle, all outputs at reset values; a subsequent load of the same address misses.
- mem_ready high continuously, store miss at 0x0020 with DataIn=0x00FF → Done at cycle 2; a later load of 0x0020 hits with 0x00FF, and its eviction by 0x0120 produces a write-back of 0x00FF.
